// File: rtl/score_display.sv
// Binary score (0-99, saturating) to two BCD digits via double-dabble FSM, driving a
// two-digit multiplexed seven-segment display. Optional macro: LEADING_ZERO_BLANK_EN.
module score_display #(
  parameter int BW      = 7,
  parameter int MUX_DIV = 1024
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [BW-1:0] value_i,
  output logic [6:0]    seg_o,
  output logic [1:0]    dig_sel_o,
  output logic [3:0]    bcd_tens_o,
  output logic [3:0]    bcd_units_o,
  output logic          valid_o
);

  localparam int SW = (BW > 7) ? BW : 7;
  localparam int CW = $clog2(BW + 1);
  localparam int PW = $clog2(MUX_DIV);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   bin_q, bin_d;
  logic [7:0]      scratch_q, scratch_d;
  logic [7:0]      adj;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      tens_q, tens_d;
  logic [3:0]      units_q, units_d;
  logic            valid_q, valid_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [1:0]      dig_sel_q, dig_sel_d;
  logic [6:0]      seg_q, seg_d;
  logic [SW-1:0]   val_ext;
  logic [SW-1:0]   sat;
  logic [3:0]      digit;

  // Saturation happens before conversion, so an 8-bit scratch always suffices.
  assign val_ext = SW'(value_i);
  assign sat     = (val_ext > SW'(99)) ? SW'(99) : val_ext;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h00;
    endcase
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = SHIFT;
      SHIFT:   if (cnt_q == CW'(BW - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bin_d     = bin_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    tens_d    = tens_q;
    units_d   = units_q;
    valid_d   = 1'b0;
    adj[3:0]  = (scratch_q[3:0] >= 4'd5) ? scratch_q[3:0] + 4'd3 : scratch_q[3:0];
    adj[7:4]  = (scratch_q[7:4] >= 4'd5) ? scratch_q[7:4] + 4'd3 : scratch_q[7:4];
    case (state_q)
      IDLE: begin
        bin_d     = sat[BW-1:0];
        scratch_d = 8'h00;
        cnt_d     = '0;
      end
      SHIFT: begin
        {scratch_d, bin_d} = {adj, bin_q} << 1;
        cnt_d              = cnt_q + CW'(1);
      end
      DONE: begin
        tens_d  = scratch_q[7:4];
        units_d = scratch_q[3:0];
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Segment pattern follows the digit selected on the same edge so seg and select never skew.
  always_comb begin
    pre_d     = (pre_q == PW'(MUX_DIV - 1)) ? '0 : pre_q + PW'(1);
    dig_sel_d = (pre_q == PW'(MUX_DIV - 1)) ? {dig_sel_q[0], dig_sel_q[1]} : dig_sel_q;
    digit     = dig_sel_d[1] ? tens_q : units_q;
    seg_d     = decode(digit);
`ifdef LEADING_ZERO_BLANK_EN
    if (dig_sel_d[1] && (tens_q == 4'd0)) seg_d = 7'h00;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bin_q     <= '0;
      scratch_q <= 8'h00;
      cnt_q     <= '0;
      tens_q    <= 4'd0;
      units_q   <= 4'd0;
      valid_q   <= 1'b0;
      pre_q     <= '0;
      dig_sel_q <= 2'b01;
      seg_q     <= 7'h00;
    end else begin
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      tens_q    <= tens_d;
      units_q   <= units_d;
      valid_q   <= valid_d;
      pre_q     <= pre_d;
      dig_sel_q <= dig_sel_d;
      seg_q     <= seg_d;
    end
  end

  assign seg_o       = seg_q;
  assign dig_sel_o   = dig_sel_q;
  assign bcd_tens_o  = tens_q;
  assign bcd_units_o = units_q;
  assign valid_o     = valid_q;

endmodule
